alu_writeback: RTL

//  Writeback stage directly downstream of the ALU. It accepts ALU results over a valid/ready handshake
//  and buffers them in a small FIFO. It retires each result into a 16x32 register file (r0-r15) and the CPSR.
//  It supplies the decoder with two bypassed read ports and a PC-redirect pulse when r15 is written.

---
 rtl/alu_writeback.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: buffers results in a small FIFO and retires them
// into a 16-entry register file and the CPSR, with bypassed decoder read ports.
module alu_writeback #(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] CPSR_RESET = 32'h0000_00D3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [31:0]       in_cpsr,
    input  logic              in_w,
    input  logic              in_w2,
    input  logic              in_setflags,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [31:0]       cpsr_out,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_redirect_addr,
    output logic              idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [3:0]        nzcv;
        logic              w;
        logic              w2;
        logic              setFlags;
        logic [3:0]        rd;
        logic [3:0]        rn;
    } entry_t;

    typedef enum logic {S_W1, S_W2} state_t;

    entry_t            fifoMem [FIFO_DEPTH];
    entry_t            entryIn;
    entry_t            head;
    logic [PTR_W-1:0]  headPtr, tailPtr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop;
    state_t            state, stateNext;

    logic              wEn;
    logic [3:0]        wAddr;
    logic [DATA_W-1:0] wData;
    logic              flagWr;

    logic [DATA_W-1:0] regFile [16];
    logic [31:0]       cpsrReg;
    logic              unusedCpsrBits;

    assign unusedCpsrBits = ^in_cpsr[27:0];

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign head     = fifoMem[headPtr];
    assign idle     = empty && (state == S_W1);
    assign cpsr_out = cpsrReg;

    assign entryIn = '{data1: in_data1, data2: in_data2, nzcv: in_cpsr[31:28],
                       w: in_w, w2: in_w2, setFlags: in_setflags, rd: in_rd, rn: in_rn};

    // Payload storage carries no reset; occupancy is governed by count.
    always_ff @(posedge clk) begin
        if (push) fifoMem[tailPtr] <= entryIn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            state   <= S_W1;
        end else begin
            state <= stateNext;
            if (push) tailPtr <= tailPtr + PTR_W'(1);
            if (pop)  headPtr <= headPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Retire the head entry; at most one register write per cycle.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        wEn       = 1'b0;
        wAddr     = '0;
        wData     = '0;
        flagWr    = 1'b0;
        if (!empty) begin
            case (state)
                S_W1: begin
                    wEn    = head.w;
                    wAddr  = head.rd;
                    wData  = head.data1;
                    flagWr = head.setFlags;
                    if (head.w2) stateNext = S_W2;
                    else         pop       = 1'b1;
                end
                S_W2: begin
                    wEn       = 1'b1;
                    wAddr     = head.rn;
                    wData     = head.data2;
                    pop       = 1'b1;
                    stateNext = S_W1;
                end
                default: stateNext = S_W1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regFile[i] <= '0;
            cpsrReg          <= CPSR_RESET;
            pc_redirect      <= 1'b0;
            pc_redirect_addr <= '0;
        end else begin
            if (wEn) regFile[wAddr] <= wData;
            if (flagWr) cpsrReg[31:28] <= head.nzcv;
            pc_redirect <= wEn && (wAddr == 4'd15);
            if (wEn && (wAddr == 4'd15)) pc_redirect_addr <= wData;
        end
    end

    assign rd_data_a = (wEn && (wAddr == rd_addr_a)) ? wData : regFile[rd_addr_a];
    assign rd_data_b = (wEn && (wAddr == rd_addr_b)) ? wData : regFile[rd_addr_b];

endmodule
